// File: rtl/traceback_unit_pkg.sv
// traceback_unit shared types: direction-word fields, op codes, FSM states.
// Run-length merging is compiled in with `define TRACEBACK_RLE_EN.
package traceback_unit_pkg;

  localparam int ADDRESS_WIDTH   = 8;
  localparam int DIRECTION_WIDTH = 5;

  localparam int DIR_DIAG_BIT = 4;
  localparam int DIR_LONG_BIT = 3;
  localparam int DIR_EF_BIT   = 2;

  localparam logic [1:0] OP_M = 2'd0;
  localparam logic [1:0] OP_I = 2'd1;
  localparam logic [1:0] OP_D = 2'd2;

  localparam logic [ADDRESS_WIDTH-1:0] LEN_ONE = ADDRESS_WIDTH'(1);
  localparam logic [ADDRESS_WIDTH-1:0] LEN_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECIDE,
    ST_FLUSH,
    ST_FINISH
  } state_e;

  typedef struct packed {
    logic [1:0]               code;
    logic [ADDRESS_WIDTH-1:0] len;
  } op_word_t;

endpackage

// File: rtl/traceback_unit_rle_packer.sv
// tb_rle_packer: open run plus 1-entry output register with valid/ready.
// `define TRACEBACK_RLE_EN merges equal ops; otherwise each step is len 1.
module tb_rle_packer
  import traceback_unit_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_i,
  input  logic                     step_i,
  input  logic [1:0]               op_i,
  input  logic                     flush_i,
  output logic                     accept_o,
  output logic                     op_valid_o,
  output logic [1:0]               op_code_o,
  output logic [ADDRESS_WIDTH-1:0] op_len_o,
  input  logic                     op_ready_i
);

  logic     slot_free;
  logic     push;
  op_word_t push_word;

  assign slot_free = !op_valid_o || op_ready_i;

`ifdef TRACEBACK_RLE_EN
  logic                     run_vld;
  logic [1:0]               run_op;
  logic [ADDRESS_WIDTH-1:0] run_len;
  logic                     brk;
  logic                     need;

  always_comb begin
    brk = run_vld &&
      (op_i != run_op || run_len == LEN_MAX);
    need = 1'b0;
    if (step_i) need = brk;
    else if (flush_i) need = run_vld;
    accept_o  = !need || slot_free;
    push      = need && slot_free;
    push_word = '{code: run_op, len: run_len};
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      run_vld <= 1'b0;
      run_op  <= OP_M;
      run_len <= '0;
    end else if (step_i && accept_o) begin
      run_vld <= 1'b1;
      if (brk || !run_vld) begin
        run_op  <= op_i;
        run_len <= LEN_ONE;
      end else begin
        run_len <= run_len + LEN_ONE;
      end
    end else if (flush_i && accept_o) begin
      run_vld <= 1'b0;
    end
  end
`else
  logic unused_flush;

  assign unused_flush = flush_i;

  always_comb begin
    accept_o  = !step_i || slot_free;
    push      = step_i && slot_free;
    push_word = '{code: op_i, len: LEN_ONE};
  end
`endif

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      op_valid_o <= 1'b0;
      op_code_o  <= OP_M;
      op_len_o   <= '0;
    end else if (push) begin
      op_valid_o <= 1'b1;
      op_code_o  <= push_word.code;
      op_len_o   <= push_word.len;
    end else if (op_ready_i) begin
      op_valid_o <= 1'b0;
    end
  end

endmodule

// File: rtl/traceback_unit.sv
// traceback_unit: walks direction RAM back from the max cell, emits edit ops.
// Optional `define TRACEBACK_RLE_EN enables run-length merging in the packer.
module traceback_unit
  import traceback_unit_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_i,
  input  logic                       start_i,
  input  logic [ADDRESS_WIDTH-1:0]   max_x_i,
  input  logic [ADDRESS_WIDTH-1:0]   max_y_i,
  output logic                       rd_en_o,
  output logic [ADDRESS_WIDTH-1:0]   rd_col_o,
  output logic [ADDRESS_WIDTH-1:0]   rd_row_o,
  input  logic [DIRECTION_WIDTH-1:0] rd_data_i,
  output logic                       op_valid_o,
  input  logic                       op_ready_i,
  output logic [1:0]                 op_code_o,
  output logic [ADDRESS_WIDTH-1:0]   op_len_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [ADDRESS_WIDTH-1:0]   end_x_o,
  output logic [ADDRESS_WIDTH-1:0]   end_y_o
);

  localparam int AW = ADDRESS_WIDTH;

  state_e state_q, state_d;

  logic [AW-1:0] x_q, y_q, x_nx, y_nx;
  logic [AW-1:0] end_x_q, end_y_q;
  logic          gap_q, long_q, gap_n, long_n;
  logic [1:0]    gop_q, gop_n;
  logic [DIRECTION_WIDTH-1:0] dir_q, d;
  logic          rd_vld_q;
  logic [1:0]    f;
  logic          dec_step, dx, dy;
  logic [1:0]    dec_op;
  logic          pk_step, pk_flush, pk_accept;
  logic          edge_start, at_edge;

  assign edge_start = max_x_i == '0 || max_y_i == '0;

  // A stalled DECIDE reuses the captured word; rd_data_i is only good once.
  assign d = rd_vld_q ? rd_data_i : dir_q;
  assign f = long_q ? d[1:0] : d[3:2];

  always_comb begin
    dec_step = 1'b0;
    dec_op   = OP_M;
    dx       = 1'b0;
    dy       = 1'b0;
    gap_n    = gap_q;
    long_n   = long_q;
    gop_n    = gop_q;
    unique case (1'b1)
      gap_q: begin
        dec_step = 1'b1;
        dec_op   = gop_q;
        dx       = gop_q == OP_I;
        dy       = gop_q == OP_D;
        if (d[DIR_DIAG_BIT] && f == 2'b00) gap_n = 1'b0;
      end
      (!gap_q && d[DIR_DIAG_BIT]): begin
        dec_step = 1'b1;
        dx       = 1'b1;
        dy       = 1'b1;
      end
      (!gap_q && !d[DIR_DIAG_BIT] && d[1:0] == 2'b11): begin
        dec_step = 1'b1;
        dec_op   = d[DIR_EF_BIT] ? OP_D : OP_I;
        dx       = !d[DIR_EF_BIT];
        dy       = d[DIR_EF_BIT];
        gap_n    = 1'b1;
        long_n   = d[DIR_LONG_BIT];
        gop_n    = dec_op;
      end
      default: ;
    endcase
  end

  assign x_nx    = x_q - AW'(dx);
  assign y_nx    = y_q - AW'(dy);
  assign at_edge = x_nx == '0 || y_nx == '0;

  assign pk_step  = state_q == ST_DECIDE && dec_step;
  assign pk_flush = state_q == ST_FLUSH;

  tb_rle_packer u_pack (
    .clk        (clk),
    .reset_i    (reset_i),
    .step_i     (pk_step),
    .op_i       (dec_op),
    .flush_i    (pk_flush),
    .accept_o   (pk_accept),
    .op_valid_o (op_valid_o),
    .op_code_o  (op_code_o),
    .op_len_o   (op_len_o),
    .op_ready_i (op_ready_i)
  );

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (start_i)
          state_d = edge_start ? ST_FINISH : ST_FETCH;
      ST_FETCH:
        state_d = ST_DECIDE;
      ST_DECIDE:
        if (!dec_step)
          state_d = ST_FLUSH;
        else if (pk_accept)
          state_d = at_edge ? ST_FLUSH : ST_FETCH;
      ST_FLUSH:
        if (pk_accept) state_d = ST_FINISH;
      ST_FINISH:
        if (!op_valid_o) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_en_o  = state_q == ST_FETCH;
    rd_col_o = x_q;
    rd_row_o = y_q;
    busy_o   = state_q != ST_IDLE;
    done_o   = state_q == ST_FINISH && !op_valid_o;
    end_x_o  = end_x_q;
    end_y_o  = end_y_q;
  end

  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      x_q      <= '0;
      y_q      <= '0;
      gap_q    <= 1'b0;
      long_q   <= 1'b0;
      gop_q    <= OP_M;
      dir_q    <= '0;
      rd_vld_q <= 1'b0;
      end_x_q  <= '0;
      end_y_q  <= '0;
    end else begin
      rd_vld_q <= state_q == ST_FETCH;
      if (rd_vld_q) dir_q <= rd_data_i;
      if (state_q == ST_IDLE && start_i) begin
        x_q    <= max_x_i;
        y_q    <= max_y_i;
        gap_q  <= 1'b0;
        long_q <= 1'b0;
        gop_q  <= OP_M;
        if (edge_start) begin
          end_x_q <= max_x_i;
          end_y_q <= max_y_i;
        end
      end
      if (pk_step && pk_accept) begin
        x_q    <= x_nx;
        y_q    <= y_nx;
        gap_q  <= gap_n;
        long_q <= long_n;
        gop_q  <= gop_n;
      end
      if (pk_flush && pk_accept) begin
        end_x_q <= x_q;
        end_y_q <= y_q;
      end
    end
  end

endmodule

// File: tb/tb_traceback_unit.sv
// Directed bench for traceback_unit: RAM model, op monitor, fixed walks.
// Expected streams follow whether TRACEBACK_RLE_EN is defined.
module tb_traceback_unit;
  import traceback_unit_pkg::*;

  localparam int AW = ADDRESS_WIDTH;

  logic          clk = 1'b0;
  logic          reset_i = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] max_x_i = '0;
  logic [AW-1:0] max_y_i = '0;
  logic          rd_en_o;
  logic [AW-1:0] rd_col_o, rd_row_o;
  logic [4:0]    rd_data_i;
  logic          op_valid_o;
  logic          op_ready_i = 1'b1;
  logic [1:0]    op_code_o;
  logic [AW-1:0] op_len_o;
  logic          busy_o, done_o;
  logic [AW-1:0] end_x_o, end_y_o;

  traceback_unit dut (
    .clk        (clk),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .max_x_i    (max_x_i),
    .max_y_i    (max_y_i),
    .rd_en_o    (rd_en_o),
    .rd_col_o   (rd_col_o),
    .rd_row_o   (rd_row_o),
    .rd_data_i  (rd_data_i),
    .op_valid_o (op_valid_o),
    .op_ready_i (op_ready_i),
    .op_code_o  (op_code_o),
    .op_len_o   (op_len_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .end_x_o    (end_x_o),
    .end_y_o    (end_y_o)
  );

  always #5 clk = ~clk;

  logic [4:0]    mem [16][16];
  logic [AW+1:0] got[$];
  logic [AW+1:0] exp_q[$];
  int n_rd = 0;
  int n_done = 0;
  int passed = 0;
  int total = 0;

  // Word is valid one cycle after rd_en; otherwise a poison value.
  always @(posedge clk or negedge reset_i) begin
    if (!reset_i) rd_data_i <= 5'd0;
    else if (rd_en_o) rd_data_i <= mem[rd_col_o[3:0]][rd_row_o[3:0]];
    else rd_data_i <= 5'b00101;
  end

  always @(posedge clk) begin
    if (reset_i) begin
      if (op_valid_o && op_ready_i) got.push_back({op_code_o, op_len_o});
      if (rd_en_o) n_rd <= n_rd + 1;
      if (done_o) n_done <= n_done + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [AW+1:0] ow(input logic [1:0] c, input int l);
    return {c, AW'(l)};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        mem[i][j] = 5'd0;
  endtask

  task automatic start_walk(input int sx, input int sy);
    @(negedge clk);
    max_x_i = AW'(sx);
    max_y_i = AW'(sy);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!done_o && k < 500) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, 32'(done_o), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int base);
    int n;
    n = got.size() - base;
    check({tag, "_nops"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      check({tag, "_op"}, 32'(got[base+i]), 32'(exp_q[i]));
  endtask

  task automatic finish_walk(input string tag, input int ex, input int ey,
                             input int base, input int rb, input int nr);
    int db;
    wait_done(tag);
    check({tag, "_end"}, {end_x_o, end_y_o}, {AW'(ex), AW'(ey)});
    db = n_done;
    @(negedge clk);
    check({tag, "_pulse"}, {29'd0, done_o, busy_o, 1'b0},
          32'd0);
    check({tag, "_donecnt"}, n_done - db, 1);
    check({tag, "_reads"}, n_rd - rb, nr);
    check_stream(tag, base);
  endtask

  function automatic logic [31:0] all_outs();
    return {2'b0, rd_en_o, op_valid_o, busy_o, done_o, op_code_o,
            op_len_o, end_x_o, end_y_o};
  endfunction

  initial begin
    int base, rb, db, k, bad_stable, bad_rd;
    logic [AW+1:0] hold;

    clear_mem();
    repeat (3) @(negedge clk);
    check("reset_outs", all_outs(), 32'd0);
    check("reset_addr", {rd_col_o, rd_row_o}, 32'd0);
    reset_i = 1'b1;
    @(negedge clk);

    // Pure diagonal
    mem[3][3] = 5'b10000;
    mem[2][2] = 5'b10000;
    mem[1][1] = 5'b10000;
    exp_q = {};
`ifdef TRACEBACK_RLE_EN
    exp_q.push_back(ow(OP_M, 3));
`else
    repeat (3) exp_q.push_back(ow(OP_M, 1));
`endif
    base = got.size();
    rb = n_rd;
    start_walk(3, 3);
    finish_walk("diag", 0, 0, base, rb, 3);

    // Short insertion gap then diagonal
    clear_mem();
    mem[4][2] = 5'b00011;
    mem[3][2] = 5'b10100;
    mem[2][2] = 5'b10000;
    mem[1][2] = 5'b10000;
    exp_q = {};
`ifdef TRACEBACK_RLE_EN
    exp_q.push_back(ow(OP_I, 3));
    exp_q.push_back(ow(OP_M, 1));
`else
    repeat (3) exp_q.push_back(ow(OP_I, 1));
    exp_q.push_back(ow(OP_M, 1));
`endif
    base = got.size();
    rb = n_rd;
    start_walk(4, 2);
    finish_walk("ins", 0, 1, base, rb, 4);

    // Long deletion gap then diagonal
    clear_mem();
    mem[2][5] = 5'b01111;
    mem[2][4] = 5'b10001;
    mem[2][3] = 5'b10000;
    mem[2][2] = 5'b10000;
    mem[1][1] = 5'b10000;
    exp_q = {};
`ifdef TRACEBACK_RLE_EN
    exp_q.push_back(ow(OP_D, 3));
    exp_q.push_back(ow(OP_M, 2));
`else
    repeat (3) exp_q.push_back(ow(OP_D, 1));
    repeat (2) exp_q.push_back(ow(OP_M, 1));
`endif
    base = got.size();
    rb = n_rd;
    start_walk(2, 5);
    finish_walk("del", 0, 0, base, rb, 5);

    // Backpressure: M, I-gap, M with ready low for 10 cycles
    clear_mem();
    mem[4][4] = 5'b10000;
    mem[3][3] = 5'b00011;
    mem[2][3] = 5'b10000;
    mem[1][3] = 5'b10000;
    exp_q = {};
`ifdef TRACEBACK_RLE_EN
    exp_q.push_back(ow(OP_M, 1));
    exp_q.push_back(ow(OP_I, 2));
    exp_q.push_back(ow(OP_M, 1));
`else
    exp_q.push_back(ow(OP_M, 1));
    repeat (2) exp_q.push_back(ow(OP_I, 1));
    exp_q.push_back(ow(OP_M, 1));
`endif
    base = got.size();
    rb = n_rd;
    op_ready_i = 1'b0;
    start_walk(4, 4);
    k = 0;
    while (!op_valid_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("bp_valid", 32'(op_valid_o), 32'd1);
    hold = {op_code_o, op_len_o};
    check("bp_first", 32'(hold), 32'(ow(OP_M, 1)));
    bad_stable = 0;
    bad_rd = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ({op_valid_o, op_code_o, op_len_o} !== {1'b1, hold})
        bad_stable++;
      if (i >= 6 && rd_en_o) bad_rd++;
    end
    check("bp_stable", bad_stable, 0);
    check("bp_no_read", bad_rd, 0);
    check("bp_busy", 32'(busy_o), 32'd1);
    op_ready_i = 1'b1;
    finish_walk("bp", 0, 2, base, rb, 4);

    // Edge start: no ops, done one cycle after start
    base = got.size();
    rb = n_rd;
    start_walk(5, 0);
    check("edge_done", {30'd0, done_o, busy_o}, 32'd3);
    check("edge_end", {end_x_o, end_y_o}, {AW'(5), AW'(0)});
    @(negedge clk);
    check("edge_idle", {30'd0, done_o, busy_o}, 32'd0);
    check("edge_nops", got.size() - base, 0);
    check("edge_reads", n_rd - rb, 0);

    // Start while busy is ignored
    clear_mem();
    mem[3][3] = 5'b10000;
    mem[2][2] = 5'b10000;
    mem[1][1] = 5'b10000;
    mem[7][7] = 5'b01111;
    exp_q = {};
`ifdef TRACEBACK_RLE_EN
    exp_q.push_back(ow(OP_M, 3));
`else
    repeat (3) exp_q.push_back(ow(OP_M, 1));
`endif
    base = got.size();
    rb = n_rd;
    start_walk(3, 3);
    @(negedge clk);
    max_x_i = AW'(7);
    max_y_i = AW'(7);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    finish_walk("busy_start", 0, 0, base, rb, 3);

    // Reset in the middle of the walk, then a clean rerun
    rb = n_rd;
    db = n_done;
    start_walk(3, 3);
    k = 0;
    while (n_rd - rb < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("mid_reached", n_rd - rb, 2);
    reset_i = 1'b0;
    #1;
    check("mid_reset_outs", all_outs(), 32'd0);
    check("mid_reset_addr", {rd_col_o, rd_row_o}, 32'd0);
    @(negedge clk);
    reset_i = 1'b1;
    @(negedge clk);
    check("mid_no_done", n_done - db, 0);
    base = got.size();
    rb = n_rd;
    start_walk(3, 3);
    finish_walk("rerun", 0, 0, base, rb, 3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
